timer_regs: RTL and testbench

//  Register bank and 64-bit counter core of the timer, directly downstream of the APB slave bridge.

---
 rtl/timer_regs_if.sv | 13 +
 rtl/timer_regs.sv | 94 +++++++++
 tb/tb_timer_regs.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/timer_regs_if.sv
// Decoded register-access bus between the APB bridge and the timer register bank.
// The bridge side drives the request; the register bank returns rdata and error in the same cycle.
interface timer_regs_if;
  logic [11:0] reg_addr;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        error;

  modport master (output reg_addr, wr_en, rd_en, wdata, input  rdata, error);
  modport slave  (input  reg_addr, wr_en, rd_en, wdata, output rdata, error);
endinterface

// File: rtl/timer_regs.sv
// Timer register bank: control, 64-bit prescaled counter, compare and level interrupt.
// Accesses are decoded combinationally; all state updates on the access edge.
module timer_regs #(
  parameter int          DIV_MAX = 8,
  parameter logic [63:0] CMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic          clk,
  input  logic          rst_n,
  timer_regs_if.slave   bus,
  output logic          tim_int
);
  localparam logic [11:0] A_TCR   = 12'h000;
  localparam logic [11:0] A_TDR0  = 12'h004;
  localparam logic [11:0] A_TDR1  = 12'h008;
  localparam logic [11:0] A_TCMP0 = 12'h00C;
  localparam logic [11:0] A_TCMP1 = 12'h010;
  localparam logic [11:0] A_TIER  = 12'h014;
  localparam logic [11:0] A_TISR  = 12'h018;
  localparam logic [3:0]  DIV_LIM = 4'(DIV_MAX);

  logic        timer_en, div_en;
  logic [3:0]  div_val;
  logic [7:0]  presc;
  logic [63:0] counter, cmp;
  logic        int_en, int_st;

  logic        acc, addr_err, tcr_bad, we, tick;
  logic [7:0]  presc_lim;

  assign acc      = bus.wr_en | bus.rd_en;
  assign addr_err = (bus.reg_addr[1:0] != 2'b00) || (bus.reg_addr > A_TISR);
  // Divider settings may only change while the timer is off before and after the write.
  assign tcr_bad  = (bus.wdata[11:8] > DIV_LIM) ||
                    ((timer_en | bus.wdata[0]) &&
                     ((bus.wdata[1] != div_en) || (bus.wdata[11:8] != div_val)));
  assign bus.error = acc & (addr_err | (bus.wr_en & (bus.reg_addr == A_TCR) & tcr_bad));
  assign we        = bus.wr_en & ~bus.error;

  assign presc_lim = ~(8'hFF << div_val);
  assign tick      = timer_en & (div_en ? (presc == presc_lim) : 1'b1);
  assign tim_int   = int_st & int_en;

  always_comb begin
    bus.rdata = 32'h0;
    if (bus.rd_en && !bus.error) begin
      unique case (bus.reg_addr)
        A_TCR:   bus.rdata = {20'h0, div_val, 6'h0, div_en, timer_en};
        A_TDR0:  bus.rdata = counter[31:0];
        A_TDR1:  bus.rdata = counter[63:32];
        A_TCMP0: bus.rdata = cmp[31:0];
        A_TCMP1: bus.rdata = cmp[63:32];
        A_TIER:  bus.rdata = {31'h0, int_en};
        A_TISR:  bus.rdata = {31'h0, int_st};
        default: bus.rdata = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_en <= 1'b0;
      div_en   <= 1'b0;
      div_val  <= 4'd1;
      presc    <= 8'h0;
      counter  <= 64'h0;
      cmp      <= CMP_RST;
      int_en   <= 1'b0;
      int_st   <= 1'b0;
    end else begin
      if (we && bus.reg_addr == A_TCR) begin
        timer_en <= bus.wdata[0];
        div_en   <= bus.wdata[1];
        div_val  <= bus.wdata[11:8];
        presc    <= 8'h0;
      end else if (!timer_en) begin
        presc <= 8'h0;
      end else if (div_en) begin
        presc <= tick ? 8'h0 : presc + 8'h1;
      end

      // A software write to either counter half takes priority over the increment.
      if (we && bus.reg_addr == A_TDR0)      counter <= {counter[63:32], bus.wdata};
      else if (we && bus.reg_addr == A_TDR1) counter <= {bus.wdata, counter[31:0]};
      else if (tick)                         counter <= counter + 64'h1;

      if (we && bus.reg_addr == A_TCMP0) cmp[31:0]  <= bus.wdata;
      if (we && bus.reg_addr == A_TCMP1) cmp[63:32] <= bus.wdata;
      if (we && bus.reg_addr == A_TIER)  int_en     <= bus.wdata[0];

      if (counter == cmp)                                   int_st <= 1'b1;
      else if (we && bus.reg_addr == A_TISR && bus.wdata[0]) int_st <= 1'b0;
    end
  end
endmodule

// File: tb/tb_timer_regs.sv
// Directed bench for timer_regs: register map, prescaler, counter carry/wrap, compare interrupt, errors.
module tb_timer_regs;
  logic clk = 1'b0;
  logic rst_n;
  logic tim_int;
  int   checks = 0;
  int   failures = 0;

  localparam logic [11:0] A_TCR = 12'h000, A_TDR0 = 12'h004, A_TDR1 = 12'h008,
                          A_TCMP0 = 12'h00C, A_TCMP1 = 12'h010, A_TIER = 12'h014, A_TISR = 12'h018;

  timer_regs_if bus ();
  timer_regs #(.DIV_MAX(8), .CMP_RST(64'hFFFF_FFFF_FFFF_FFFF)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .tim_int(tim_int));

  always #5 clk = ~clk;

  task automatic wr(input logic [11:0] a, input logic [31:0] d, output logic e);
    @(negedge clk);
    bus.reg_addr = a; bus.wdata = d; bus.wr_en = 1'b1;
    #1 e = bus.error;
    @(posedge clk);
    #1 bus.wr_en = 1'b0;
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] d, output logic e);
    @(negedge clk);
    bus.reg_addr = a; bus.rd_en = 1'b1;
    #1 d = bus.rdata; e = bus.error;
    #1 bus.rd_en = 1'b0;
  endtask

  task automatic do_reset();
    bus.reg_addr = '0; bus.wdata = '0; bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] d; logic e;
    logic [11:0] addrs [7] = '{A_TCR, A_TDR0, A_TDR1, A_TCMP0, A_TCMP1, A_TIER, A_TISR};
    logic [31:0] exp   [7] = '{32'h100, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0};
    bus.reg_addr = '0; bus.wdata = '0; bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    rst_n = 1'b0;
    #12;
    checks++;
    if (bus.rdata !== 32'h0 || bus.error !== 1'b0 || tim_int !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs rdata=%h error=%b tim_int=%b required 0/0/0", bus.rdata, bus.error, tim_int);
    end
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      rd(addrs[i], d, e);
      checks++;
      if (d !== exp[i] || e !== 1'b0) begin
        failures++;
        $display("FAIL reset_read addr=%h got=%h err=%b required=%h err=0", addrs[i], d, e, exp[i]);
      end
    end
  endtask

  task automatic test_count_nodiv();
    logic [31:0] d; logic e;
    do_reset();
    wr(A_TCR, 32'h0, e);
    wr(A_TCR, 32'h1, e);
    checks++;
    if (e !== 1'b0) begin failures++; $display("FAIL tcr_enable_err got=%b required=0", e); end
    repeat (10) @(posedge clk);
    rd(A_TDR0, d, e);
    checks++;
    if (d < 9 || d > 11) begin failures++; $display("FAIL count_10 got=%0d required=10+-1", d); end
    rd(A_TDR1, d, e);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL count_hi got=%h required=0", d); end
  endtask

  task automatic test_prescaler();
    logic [31:0] d, a; logic e;
    do_reset();
    wr(A_TCR, 32'h302, e);
    wr(A_TCR, 32'h303, e);
    repeat (32) @(posedge clk);
    rd(A_TDR0, a, e);
    checks++;
    if (a !== 32'd4) begin failures++; $display("FAIL div8_after32 got=%0d required=4", a); end
    repeat (8) @(posedge clk);
    rd(A_TDR0, d, e);
    checks++;
    if (d !== a + 1) begin failures++; $display("FAIL div8_step got=%0d required=%0d", d, a + 1); end
    wr(A_TCR, 32'h203, e);
    checks++;
    if (e !== 1'b1) begin failures++; $display("FAIL tcr_div_change_err got=%b required=1", e); end
    rd(A_TCR, d, e);
    checks++;
    if (d !== 32'h303) begin failures++; $display("FAIL tcr_unchanged got=%h required=303", d); end
  endtask

  task automatic test_carry_wrap();
    logic [31:0] lo, hi; logic e;
    do_reset();
    wr(A_TDR0, 32'hFFFF_FFFE, e);
    wr(A_TDR1, 32'h0, e);
    wr(A_TCR, 32'h0, e);
    wr(A_TCR, 32'h1, e);
    @(posedge clk);
    wr(A_TCR, 32'h0, e);
    rd(A_TDR0, lo, e); rd(A_TDR1, hi, e);
    checks++;
    if (lo !== 32'h0 || hi !== 32'h1) begin
      failures++; $display("FAIL carry got=%h_%h required=00000001_00000000", hi, lo);
    end
    wr(A_TDR0, 32'hFFFF_FFFF, e);
    wr(A_TDR1, 32'hFFFF_FFFF, e);
    wr(A_TCR, 32'h1, e);
    wr(A_TCR, 32'h0, e);
    rd(A_TDR0, lo, e); rd(A_TDR1, hi, e);
    checks++;
    if (lo !== 32'h0 || hi !== 32'h0) begin
      failures++; $display("FAIL wrap got=%h_%h required=0_0", hi, lo);
    end
    // write lands on a tick edge: write wins, then one more tick on the stopping edge
    wr(A_TCR, 32'h1, e);
    wr(A_TDR0, 32'h100, e);
    wr(A_TCR, 32'h0, e);
    rd(A_TDR0, lo, e);
    checks++;
    if (lo !== 32'h101) begin failures++; $display("FAIL write_vs_tick got=%h required=101", lo); end
  endtask

  task automatic test_compare_int();
    logic [31:0] d; logic e, ti; bit found;
    do_reset();
    wr(A_TCMP0, 32'h5, e);
    wr(A_TCMP1, 32'h0, e);
    wr(A_TIER, 32'h1, e);
    wr(A_TCR, 32'h0, e);
    wr(A_TCR, 32'h1, e);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      rd(A_TDR0, d, e);
      if (d == 32'h5) found = 1;
    end
    checks++;
    if (!found) begin failures++; $display("FAIL cmp_reach got=%0d required=5 within 40 cycles", d); end
    checks++;
    if (tim_int !== 1'b0) begin failures++; $display("FAIL int_early got=%b required=0", tim_int); end
    rd(A_TDR0, d, e);
    ti = tim_int;
    checks++;
    if (d !== 32'h6 || ti !== 1'b1) begin
      failures++; $display("FAIL int_set cnt=%0d tim_int=%b required 6/1", d, ti);
    end
    wr(A_TCR, 32'h0, e);
    wr(A_TISR, 32'h1, e);
    rd(A_TISR, d, e);
    checks++;
    if (d !== 32'h0 || tim_int !== 1'b0) begin
      failures++; $display("FAIL int_clear tisr=%h tim_int=%b required 0/0", d, tim_int);
    end
    wr(A_TDR0, 32'h5, e);
    wr(A_TISR, 32'h1, e);
    rd(A_TISR, d, e);
    checks++;
    if (d !== 32'h1 || tim_int !== 1'b1) begin
      failures++; $display("FAIL set_beats_clear tisr=%h tim_int=%b required 1/1", d, tim_int);
    end
    wr(A_TIER, 32'h0, e);
    rd(A_TISR, d, e);
    checks++;
    if (d !== 32'h1 || tim_int !== 1'b0) begin
      failures++; $display("FAIL int_mask tisr=%h tim_int=%b required 1/0", d, tim_int);
    end
  endtask

  task automatic test_errors();
    logic [31:0] d; logic e;
    do_reset();
    rd(12'h01C, d, e);
    checks++;
    if (e !== 1'b1 || d !== 32'h0) begin failures++; $display("FAIL rd_unmapped err=%b rdata=%h required 1/0", e, d); end
    rd(12'h002, d, e);
    checks++;
    if (e !== 1'b1 || d !== 32'h0) begin failures++; $display("FAIL rd_misaligned err=%b rdata=%h required 1/0", e, d); end
    wr(12'h01C, 32'h1, e);
    checks++;
    if (e !== 1'b1) begin failures++; $display("FAIL wr_unmapped err=%b required 1", e); end
    wr(12'h005, 32'hDEAD, e);
    checks++;
    if (e !== 1'b1) begin failures++; $display("FAIL wr_misaligned err=%b required 1", e); end
    rd(A_TDR0, d, e);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL misaligned_nochange tdr0=%h required 0", d); end
    wr(A_TCR, 32'h900, e);
    checks++;
    if (e !== 1'b1) begin failures++; $display("FAIL div9_err err=%b required 1", e); end
    rd(A_TCR, d, e);
    checks++;
    if (d !== 32'h100) begin failures++; $display("FAIL div9_nochange tcr=%h required 100", d); end
    wr(A_TCR, 32'h800, e);
    checks++;
    if (e !== 1'b0) begin failures++; $display("FAIL div8_ok err=%b required 0", e); end
  endtask

  initial begin
    test_reset();
    test_count_nodiv();
    test_prescaler();
    test_carry_wrap();
    test_compare_int();
    test_errors();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
